// File: rtl/bsg_manycore_remote_req_issue_if.sv
// Request and packet channels of the remote-request issue stage, named from the stage's side.
// Latency: none, wires only.
// Backpressure: ready_o gates the request channel; pkt_yumi_i and credit_return_i drive the packet side.
interface bsg_manycore_remote_req_issue_if
  #(parameter int x_cord_width_p = 4
   ,parameter int y_cord_width_p = 4
   ,parameter int addr_width_p   = 16
   ,parameter int data_width_p   = 32
  );

  localparam int mask_width_lp = data_width_p / 8;

  // request channel from the EVA->NPA translator
  logic                      v_i;
  logic                      we_i;
  logic [data_width_p-1:0]   data_i;
  logic [mask_width_lp-1:0]  mask_i;
  logic [x_cord_width_p-1:0] x_cord_i;
  logic [y_cord_width_p-1:0] y_cord_i;
  logic [addr_width_p-1:0]   epa_i;
  logic                      is_invalid_addr_i;
  logic                      ready_o;

  // packet channel toward the network
  logic                      pkt_v_o;
  logic                      pkt_yumi_i;
  logic                      pkt_we_o;
  logic [data_width_p-1:0]   pkt_data_o;
  logic [mask_width_lp-1:0]  pkt_mask_o;
  logic [x_cord_width_p-1:0] pkt_x_o;
  logic [y_cord_width_p-1:0] pkt_y_o;
  logic [addr_width_p-1:0]   pkt_addr_o;
  logic [x_cord_width_p-1:0] pkt_src_x_o;
  logic [y_cord_width_p-1:0] pkt_src_y_o;
  logic                      credit_return_i;

  modport slave
    (input  v_i, we_i, data_i, mask_i, x_cord_i, y_cord_i, epa_i, is_invalid_addr_i
    ,output ready_o
    ,output pkt_v_o, pkt_we_o, pkt_data_o, pkt_mask_o, pkt_x_o, pkt_y_o, pkt_addr_o
    ,output pkt_src_x_o, pkt_src_y_o
    ,input  pkt_yumi_i, credit_return_i
    );

  modport master
    (output v_i, we_i, data_i, mask_i, x_cord_i, y_cord_i, epa_i, is_invalid_addr_i
    ,input  ready_o
    ,input  pkt_v_o, pkt_we_o, pkt_data_o, pkt_mask_o, pkt_x_o, pkt_y_o, pkt_addr_o
    ,input  pkt_src_x_o, pkt_src_y_o
    ,output pkt_yumi_i, credit_return_i
    );

endinterface

// File: rtl/bsg_manycore_remote_req_issue.sv
// Outbound remote-request issue: buffers translated requests, sends them as credit-gated packets.
// Latency: an accepted request reaches pkt_v_o the following cycle at the earliest (no bypass).
// Backpressure: ready_o drops when the FIFO is full or a fence drains; pkt_v_o waits for credits.
// Optional counters: define BSG_MANYCORE_REQ_ISSUE_STATS_EN for stat_sent_o / stat_dropped_o.
module bsg_manycore_remote_req_issue
  #(parameter int x_cord_width_p    = 4
   ,parameter int y_cord_width_p    = 4
   ,parameter int addr_width_p      = 16
   ,parameter int data_width_p      = 32
   ,parameter int fifo_els_p        = 2
   ,parameter int max_out_credits_p = 32
   ,localparam int credit_width_lp  = $clog2(max_out_credits_p + 1)
  )
  (input  logic                       clk_i
  ,input  logic                       reset_n_i
  ,bsg_manycore_remote_req_issue_if.slave link
  ,input  logic [x_cord_width_p-1:0]  my_x_i
  ,input  logic [y_cord_width_p-1:0]  my_y_i
  ,output logic [credit_width_lp-1:0] out_credits_o
  ,input  logic                       fence_v_i
  ,output logic                       fence_done_o
  ,output logic                       err_o
  ,output logic [addr_width_p-1:0]    err_epa_o
  ,input  logic                       err_clear_i
`ifdef BSG_MANYCORE_REQ_ISSUE_STATS_EN
  ,output logic [31:0]                stat_sent_o
  ,output logic [15:0]                stat_dropped_o
`endif
  );

  localparam int mask_width_lp = data_width_p / 8;
  localparam int ptr_width_lp  = $clog2(fifo_els_p);
  localparam int cnt_width_lp  = $clog2(fifo_els_p + 1);

  typedef logic [ptr_width_lp-1:0]    ptr_t;
  typedef logic [cnt_width_lp-1:0]    cnt_t;
  typedef logic [credit_width_lp-1:0] credit_t;

  typedef struct packed {
    logic                      we;
    logic [data_width_p-1:0]   data;
    logic [mask_width_lp-1:0]  mask;
    logic [x_cord_width_p-1:0] x;
    logic [y_cord_width_p-1:0] y;
    logic [addr_width_p-1:0]   addr;
  } req_t;

  typedef enum logic {READY, FENCE} state_e;

  req_t                    mem_q [fifo_els_p];
  ptr_t                    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  cnt_t                    cnt_q, cnt_d;
  credit_t                 credits_q, credits_d;
  state_e                  state_q, state_d;
  logic                    err_q, err_d;
  logic [addr_width_p-1:0] err_epa_q, err_epa_d;

  logic fifo_full, fifo_empty, credits_full;
  logic ready, accept, drop, enq, pkt_v, send, fence_done;
  req_t enq_dat, head;

  assign fifo_full    = (cnt_q == cnt_t'(fifo_els_p));
  assign fifo_empty   = (cnt_q == '0);
  assign credits_full = (credits_q == credit_t'(max_out_credits_p));

  // ready_o does not look ahead at a same-cycle dequeue, so a full FIFO always stalls.
  assign ready  = (state_q == READY) & ~fifo_full;
  assign accept = link.v_i & ready;
  assign drop   = accept & link.is_invalid_addr_i;
  assign enq    = accept & ~link.is_invalid_addr_i;

  assign head  = mem_q[rd_ptr_q];
  assign pkt_v = ~fifo_empty & (credits_q != '0);
  assign send  = pkt_v & link.pkt_yumi_i;

  assign enq_dat.we   = link.we_i;
  assign enq_dat.data = link.data_i;
  assign enq_dat.mask = link.mask_i;
  assign enq_dat.x    = link.x_cord_i;
  assign enq_dat.y    = link.y_cord_i;
  assign enq_dat.addr = link.epa_i;

  // FIFO pointers and occupancy; enqueue and dequeue may coincide.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (enq) wr_ptr_d = (wr_ptr_q == ptr_t'(fifo_els_p - 1)) ? '0 : wr_ptr_q + ptr_t'(1);
    if (send) rd_ptr_d = (rd_ptr_q == ptr_t'(fifo_els_p - 1)) ? '0 : rd_ptr_q + ptr_t'(1);
    case ({enq, send})
      2'b10:   cnt_d = cnt_q + cnt_t'(1);
      2'b01:   cnt_d = cnt_q - cnt_t'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Credit counter: a send and a return in the same cycle cancel; returns saturate at max.
  always_comb begin
    credits_d = credits_q;
    if (send & ~link.credit_return_i)
      credits_d = credits_q - credit_t'(1);
    else if (link.credit_return_i & ~send & ~credits_full)
      credits_d = credits_q + credit_t'(1);
  end

  // Sticky error: the first dropped EPA is kept; a new drop beats a simultaneous clear.
  always_comb begin
    err_d     = err_q;
    err_epa_d = err_epa_q;
    if (drop) begin
      err_d = 1'b1;
      if (!err_q) err_epa_d = link.epa_i;
    end else if (err_clear_i) begin
      err_d     = 1'b0;
      err_epa_d = '0;
    end
  end

  // Fence FSM: leave FENCE only once the FIFO is empty and every credit is home.
  always_comb begin
    state_d    = state_q;
    fence_done = 1'b0;
    case (state_q)
      READY: if (fence_v_i) state_d = FENCE;
      FENCE: begin
        if (fifo_empty & credits_full) begin
          state_d    = READY;
          fence_done = 1'b1;
        end
      end
      default: state_d = READY;
    endcase
  end

  // State registers; reset discards anything buffered.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      credits_q <= credit_t'(max_out_credits_p);
      state_q   <= READY;
      err_q     <= 1'b0;
      err_epa_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      credits_q <= credits_d;
      state_q   <= state_d;
      err_q     <= err_d;
      err_epa_q <= err_epa_d;
    end
  end

  // Payload storage needs no reset: only entries counted by cnt_q are ever presented.
  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wr_ptr_q] <= enq_dat;
  end

`ifdef BSG_MANYCORE_REQ_ISSUE_STATS_EN
  logic [31:0] sent_q, sent_d;
  logic [15:0] dropped_q, dropped_d;

  // Wrapping event counters for sent packets and dropped requests.
  always_comb begin
    sent_d    = send ? sent_q + 32'd1 : sent_q;
    dropped_d = drop ? dropped_q + 16'd1 : dropped_q;
  end

  // Counter registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sent_q    <= '0;
      dropped_q <= '0;
    end else begin
      sent_q    <= sent_d;
      dropped_q <= dropped_d;
    end
  end

  assign stat_sent_o    = sent_q;
  assign stat_dropped_o = dropped_q;
`endif

  assign link.ready_o     = ready;
  assign link.pkt_v_o     = pkt_v;
  assign link.pkt_we_o    = head.we;
  assign link.pkt_data_o  = head.data;
  assign link.pkt_mask_o  = head.mask;
  assign link.pkt_x_o     = head.x;
  assign link.pkt_y_o     = head.y;
  assign link.pkt_addr_o  = head.addr;
  assign link.pkt_src_x_o = my_x_i;
  assign link.pkt_src_y_o = my_y_i;

  assign out_credits_o = credits_q;
  assign fence_done_o  = fence_done;
  assign err_o         = err_q;
  assign err_epa_o     = err_epa_q;

`ifndef SYNTHESIS
  // A credit can only come back for a packet that is outstanding.
  credit_return_at_max: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(link.credit_return_i & ~send & credits_full));
`endif

endmodule

// File: tb/tb_bsg_manycore_remote_req_issue.sv
// Bench for the remote-request issue stage: directed scenarios then random traffic.
// Latency: outputs are compared every negedge against a queue/counter model.
// Backpressure: pkt_yumi_i and credit_return_i are randomly withheld.
module tb_bsg_manycore_remote_req_issue;

  localparam int XW = 4, YW = 4, AW = 16, DW = 32, MW = 4, ELS = 2, MAX = 32, CW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [XW-1:0] my_x;
  logic [YW-1:0] my_y;
  logic [CW-1:0] credits;
  logic          fence_v, fence_done, err, err_clear;
  logic [AW-1:0] err_epa;
  logic          yumi_want, ret_want;
`ifdef BSG_MANYCORE_REQ_ISSUE_STATS_EN
  logic [31:0]   stat_sent;
  logic [15:0]   stat_dropped;
`endif

  bsg_manycore_remote_req_issue_if #(.x_cord_width_p(XW), .y_cord_width_p(YW),
    .addr_width_p(AW), .data_width_p(DW)) bus ();

  assign bus.pkt_yumi_i      = yumi_want & bus.pkt_v_o;
  assign bus.credit_return_i = ret_want & (credits != CW'(MAX));

  bsg_manycore_remote_req_issue #(.x_cord_width_p(XW), .y_cord_width_p(YW),
    .addr_width_p(AW), .data_width_p(DW), .fifo_els_p(ELS), .max_out_credits_p(MAX)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .link(bus), .my_x_i(my_x), .my_y_i(my_y),
    .out_credits_o(credits), .fence_v_i(fence_v), .fence_done_o(fence_done),
    .err_o(err), .err_epa_o(err_epa), .err_clear_i(err_clear)
`ifdef BSG_MANYCORE_REQ_ISSUE_STATS_EN
    , .stat_sent_o(stat_sent), .stat_dropped_o(stat_dropped)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic          we;
    logic [DW-1:0] data;
    logic [MW-1:0] mask;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [AW-1:0] a;
  } mreq_t;

  mreq_t         mq[$];
  int            m_cred;
  bit            m_fence, m_err;
  logic [AW-1:0] m_epa;
  int unsigned   m_sent, m_drop;

  initial begin
    forever begin
      bit e_ready, e_pv, e_done, acc, snd, ret;
      mreq_t r;
      @(negedge clk);
      if (!rst_n) begin
        mq.delete();
        m_cred = MAX; m_fence = 0; m_err = 0; m_epa = '0; m_sent = 0; m_drop = 0;
      end
      e_ready = !m_fence && (mq.size() < ELS);
      e_pv    = (mq.size() != 0) && (m_cred != 0);
      e_done  = m_fence && (mq.size() == 0) && (m_cred == MAX);
      chk("ready_o", 64'(bus.ready_o), 64'(e_ready));
      chk("pkt_v_o", 64'(bus.pkt_v_o), 64'(e_pv));
      chk("out_credits", 64'(credits), 64'(m_cred));
      chk("fence_done", 64'(fence_done), 64'(e_done));
      chk("err_o", 64'(err), 64'(m_err));
      chk("err_epa", 64'(err_epa), 64'(m_epa));
`ifdef BSG_MANYCORE_REQ_ISSUE_STATS_EN
      chk("stat_sent", 64'(stat_sent), 64'(m_sent));
      chk("stat_dropped", 64'(stat_dropped), 64'(16'(m_drop)));
`endif
      if (e_pv) begin
        chk("pkt_we", 64'(bus.pkt_we_o), 64'(mq[0].we));
        chk("pkt_data", 64'(bus.pkt_data_o), 64'(mq[0].data));
        chk("pkt_mask", 64'(bus.pkt_mask_o), 64'(mq[0].mask));
        chk("pkt_x", 64'(bus.pkt_x_o), 64'(mq[0].x));
        chk("pkt_y", 64'(bus.pkt_y_o), 64'(mq[0].y));
        chk("pkt_addr", 64'(bus.pkt_addr_o), 64'(mq[0].a));
        chk("pkt_src_x", 64'(bus.pkt_src_x_o), 64'(my_x));
        chk("pkt_src_y", 64'(bus.pkt_src_y_o), 64'(my_y));
      end
      if (rst_n) begin
        acc = bus.v_i && e_ready;
        snd = e_pv && yumi_want;
        ret = ret_want && (m_cred != MAX);
        if (snd) begin void'(mq.pop_front()); m_cred--; m_sent++; end
        if (ret) m_cred++;
        if (acc && bus.is_invalid_addr_i) begin
          if (!m_err) m_epa = bus.epa_i;
          m_err = 1;
          m_drop++;
        end else begin
          if (acc) begin
            r.we = bus.we_i; r.data = bus.data_i; r.mask = bus.mask_i;
            r.x = bus.x_cord_i; r.y = bus.y_cord_i; r.a = bus.epa_i;
            mq.push_back(r);
          end
          if (err_clear) begin m_err = 0; m_epa = '0; end
        end
        if (!m_fence) m_fence = fence_v;
        else if (e_done) m_fence = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic we, input logic [DW-1:0] d, input logic [AW-1:0] a,
                      input logic inv, input logic [XW-1:0] x, input logic [YW-1:0] y);
    logic acc;
    acc = 1'b0;
    bus.v_i = 1'b1; bus.we_i = we; bus.data_i = d; bus.mask_i = 4'hF;
    bus.x_cord_i = x; bus.y_cord_i = y; bus.epa_i = a; bus.is_invalid_addr_i = inv;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      acc = bus.ready_o;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    chk("push_accepted", 64'(acc), 64'(1));
    bus.v_i = 1'b0;
    bus.is_invalid_addr_i = 1'b0;
  endtask

  int pulses;

  initial begin
    rst_n = 1'b0; my_x = 4'd3; my_y = 4'd5;
    bus.v_i = 0; bus.we_i = 0; bus.data_i = '0; bus.mask_i = '0; bus.x_cord_i = '0;
    bus.y_cord_i = '0; bus.epa_i = '0; bus.is_invalid_addr_i = 0;
    fence_v = 0; err_clear = 0; yumi_want = 0; ret_want = 0;
    tick(); tick();
    chk("rst_pkt_v", 64'(bus.pkt_v_o), 64'(0));
    chk("rst_credits", 64'(credits), 64'(32));
    chk("rst_ready", 64'(bus.ready_o), 64'(1));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_fence_done", 64'(fence_done), 64'(0));
    rst_n = 1'b1;
    tick();

    // single store goes straight out
    yumi_want = 1;
    push(1'b1, 32'hDEADBEEF, 16'h0010, 1'b0, 4'd2, 4'd1);
    chk("t1_pkt_v", 64'(bus.pkt_v_o), 64'(1));
    chk("t1_pkt_x", 64'(bus.pkt_x_o), 64'(2));
    chk("t1_pkt_y", 64'(bus.pkt_y_o), 64'(1));
    chk("t1_pkt_addr", 64'(bus.pkt_addr_o), 64'(16'h10));
    chk("t1_pkt_data", 64'(bus.pkt_data_o), 64'(32'hDEADBEEF));
    chk("t1_src_x", 64'(bus.pkt_src_x_o), 64'(3));
    tick();
    chk("t1_credits", 64'(credits), 64'(31));

    // backpressure fills the FIFO
    yumi_want = 0;
    push(1'b1, 32'h1111_0000, 16'h0020, 1'b0, 4'd1, 4'd1);
    push(1'b0, 32'h2222_0000, 16'h0021, 1'b0, 4'd2, 4'd2);
    chk("t2_ready_full", 64'(bus.ready_o), 64'(0));
    bus.v_i = 1; bus.epa_i = 16'h0022;
    repeat (3) tick();
    chk("t2_head_stable", 64'(bus.pkt_addr_o), 64'(16'h20));
    yumi_want = 1;
    push(1'b1, 32'h3333_0000, 16'h0022, 1'b0, 4'd3, 4'd3);
    repeat (4) tick();
    chk("t2_credits", 64'(credits), 64'(28));

    // drain all credits
    for (int i = 0; i < 28; i++) push(1'b1, $urandom, 16'($urandom), 1'b0, 4'($urandom), 4'($urandom));
    repeat (4) tick();
    chk("t3_credits_zero", 64'(credits), 64'(0));
    push(1'b1, 32'h77, 16'h0077, 1'b0, 4'd7, 4'd7);
    repeat (2) tick();
    chk("t3_blocked", 64'(bus.pkt_v_o), 64'(0));
    ret_want = 1; tick(); ret_want = 0;
    chk("t3_one_credit", 64'(credits), 64'(1));
    chk("t3_unblocked", 64'(bus.pkt_v_o), 64'(1));
    ret_want = 1; tick(); ret_want = 0;
    chk("t3_send_and_return", 64'(credits), 64'(1));
    ret_want = 1; repeat (35) tick(); ret_want = 0;
    chk("t3_refilled", 64'(credits), 64'(32));

    // invalid addresses
    push(1'b1, 32'h5, 16'h0055, 1'b1, 4'd1, 4'd1);
    push(1'b1, 32'h6, 16'h0066, 1'b1, 4'd1, 4'd1);
    tick();
    chk("t4_err", 64'(err), 64'(1));
    chk("t4_err_epa", 64'(err_epa), 64'(16'h55));
    chk("t4_no_pkt", 64'(bus.pkt_v_o), 64'(0));
    err_clear = 1; tick(); err_clear = 0;
    chk("t4_cleared", 64'(err), 64'(0));
    err_clear = 1;
    push(1'b0, 32'h4, 16'h0044, 1'b1, 4'd1, 4'd1);
    err_clear = 0;
    chk("t4_set_wins", 64'(err), 64'(1));
    chk("t4_set_wins_epa", 64'(err_epa), 64'(16'h44));
    err_clear = 1; tick(); err_clear = 0;

    // fence with one queued and three credits outstanding
    for (int i = 0; i < 3; i++) push(1'b1, 32'(i), 16'(16'h100 + i), 1'b0, 4'd1, 4'd2);
    repeat (2) tick();
    yumi_want = 0;
    push(1'b1, 32'hF00D, 16'h0200, 1'b0, 4'd4, 4'd4);
    chk("t5_outstanding", 64'(credits), 64'(29));
    fence_v = 1; tick(); fence_v = 0;
    chk("t5_ready_fence", 64'(bus.ready_o), 64'(0));
    yumi_want = 1;
    repeat (3) tick();
    chk("t5_ready_wait", 64'(bus.ready_o), 64'(0));
    ret_want = 1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (fence_done) pulses++;
    end
    tick();
    ret_want = 0;
    chk("t5_one_pulse", 64'(pulses), 64'(1));
    chk("t5_ready_back", 64'(bus.ready_o), 64'(1));
    chk("t5_credits_home", 64'(credits), 64'(32));
    fence_v = 1; tick(); fence_v = 0;
    chk("t5_empty_fence_ready", 64'(bus.ready_o), 64'(0));
    chk("t5_empty_fence_done", 64'(fence_done), 64'(1));
    tick();
    chk("t5_empty_fence_exit", 64'(bus.ready_o), 64'(1));

    // reset in the middle of traffic
    push(1'b1, 32'hAA, 16'h0300, 1'b0, 4'd5, 4'd5);
    tick();
    yumi_want = 0;
    push(1'b1, 32'hBB, 16'h0301, 1'b0, 4'd6, 4'd6);
    chk("t6_pkt_pending", 64'(bus.pkt_v_o), 64'(1));
    chk("t6_credits_before", 64'(credits), 64'(31));
    rst_n = 0;
    #1;
    chk("t6_pkt_v_async", 64'(bus.pkt_v_o), 64'(0));
    chk("t6_credits_async", 64'(credits), 64'(32));
    tick(); tick();
    rst_n = 1;
    tick();
    chk("t6_pkt_v_after", 64'(bus.pkt_v_o), 64'(0));
    chk("t6_ready_after", 64'(bus.ready_o), 64'(1));

    // random traffic against the model
    for (int i = 0; i < 800; i++) begin
      bus.v_i = 1'($urandom);
      bus.we_i = 1'($urandom);
      bus.data_i = $urandom;
      bus.mask_i = 4'($urandom);
      bus.x_cord_i = 4'($urandom);
      bus.y_cord_i = 4'($urandom);
      bus.epa_i = 16'($urandom);
      bus.is_invalid_addr_i = ($urandom_range(0, 7) == 0);
      yumi_want = ($urandom_range(0, 3) != 0);
      ret_want = ($urandom_range(0, 2) == 0);
      fence_v = ($urandom_range(0, 49) == 0);
      err_clear = ($urandom_range(0, 15) == 0);
      tick();
    end
    bus.v_i = 0; bus.is_invalid_addr_i = 0; fence_v = 0; err_clear = 0;
    yumi_want = 1; ret_want = 1;
    repeat (80) tick();
    chk("rand_drained_credits", 64'(credits), 64'(32));
    chk("rand_drained_pkt_v", 64'(bus.pkt_v_o), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
